posit_cmd_queue: RTL and testbench



---
 rtl/posit_cmd_queue.sv | 133 +++++++++++++
 tb/tb_posit_cmd_queue.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/posit_cmd_queue.sv
// Command FIFO and one-at-a-time dispatcher between the core data bus and the
// posit vector coprocessor; the core polls STATUS/RESULT instead of stalling.
module posit_cmd_queue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        gpup_req_o,
  output logic [31:0] gpup_addr_o,
  output logic [31:0] gpup_wdata_o,
  input  logic        gpup_rvalid_i,
  input  logic [31:0] gpup_rdata_i
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]    state;
  logic [63:0]   mem [0:DEPTH-1];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic [15:0]   timer;
  logic [31:0]   result;
  logic          result_valid, err_timeout;

  logic        is_cmd, full, push, pop, busy;
  logic        rd_result, clr_err, complete, expire;
  logic [31:0] status, rmux;

  assign is_cmd = (addr_i[3:2] == 2'd0);
  assign full   = (count == CW'(DEPTH));
  // A pop this cycle does not free space for a push this cycle.
  assign gnt_o  = req_i & ~(we_i & is_cmd & full);
  assign push   = gnt_o & we_i & is_cmd;
  assign pop    = (state == S_ISSUE);

  assign rd_result = gnt_o & ~we_i & (addr_i[3:2] == 2'd2);
  assign clr_err   = gnt_o & we_i & (addr_i[3:2] == 2'd1) & wdata_i[31];
  assign complete  = (state == S_WAIT) & gpup_rvalid_i;
  assign expire    = (state == S_WAIT) & ~gpup_rvalid_i & (timer == 16'(TIMEOUT - 1));

  assign busy   = (state != S_IDLE) | (count != '0);
  assign status = {err_timeout, result_valid, busy, 21'b0, 8'(count)};

  always_comb begin
    rmux = '0;
    case (addr_i[3:2])
      2'd1:    rmux = status;
      2'd2:    rmux = result;
      default: rmux = '0;
    endcase
  end

  assign gpup_req_o   = (state == S_ISSUE);
  assign gpup_addr_o  = gpup_req_o ? mem[rptr][63:32] : '0;
  assign gpup_wdata_o = gpup_req_o ? mem[rptr][31:0]  : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {addr_i, wdata_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // timer holds (cycles since ISSUE) - 1 while in WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      timer <= '0;
    end else begin
      case (state)
        S_IDLE:  if (count != '0) state <= S_ISSUE;
        S_ISSUE: begin
          state <= S_WAIT;
          timer <= '0;
        end
        S_WAIT: begin
          timer <= timer + 1'b1;
          if (complete || expire) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result       <= '0;
      result_valid <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      if (complete) result <= gpup_rdata_i;
      if (complete)       result_valid <= 1'b1;
      else if (rd_result) result_valid <= 1'b0;
      if (expire)       err_timeout <= 1'b1;
      else if (clr_err) err_timeout <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= gnt_o;
      rdata_o  <= (gnt_o & ~we_i) ? rmux : '0;
    end
  end
endmodule

// File: tb/tb_posit_cmd_queue.sv
// Directed bench for posit_cmd_queue (DEPTH=4, TIMEOUT=8) with hand-computed
// expectations for bus responses, dispatch timing, timeout and reset.
module tb_posit_cmd_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic        gnt, rvalid;
  logic [31:0] rdata;
  logic        gpup_req;
  logic [31:0] gpup_addr, gpup_wdata;
  logic        gpup_rvalid;
  logic [31:0] gpup_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] strobes[$];

  localparam logic [31:0] A_CMD = 32'h0, A_STAT = 32'h4, A_RES = 32'h8;

  posit_cmd_queue #(.DEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .gpup_req_o(gpup_req), .gpup_addr_o(gpup_addr), .gpup_wdata_o(gpup_wdata),
    .gpup_rvalid_i(gpup_rvalid), .gpup_rdata_i(gpup_rdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (gpup_req) strobes.push_back(gpup_wdata);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Called 1ns after a posedge; returns 1ns after the next one.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input string tag);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    chk({tag, "_gnt"}, {31'b0, gnt}, 32'd1);
    tick();
    req = 1'b0; we = 1'b0;
    chk({tag, "_rv"}, {31'b0, rvalid}, 32'd1);
    chk({tag, "_rd0"}, rdata, 32'h0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    req = 1'b1; we = 1'b0; addr = a; wdata = '0;
    @(negedge clk);
    chk({tag, "_gnt"}, {31'b0, gnt}, 32'd1);
    tick();
    req = 1'b0;
    chk({tag, "_rv"}, {31'b0, rvalid}, 32'd1);
    chk(tag, rdata, exp);
  endtask

  initial begin
    int waited;
    logic [31:0] exp_q [6];
    rst = 1'b1; req = 0; we = 0; addr = 0; wdata = 0;
    gpup_rvalid = 0; gpup_rdata = 0;
    ticks(3);
    chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
    chk("rst_gpup_req", {31'b0, gpup_req}, 32'd0);
    rst = 1'b0;
    tick();

    // Reset state
    rd(A_STAT, 32'h0, "rst_status");
    chk("rst_idle_req", {31'b0, gpup_req}, 32'd0);

    // Single command, completes after 3 cycles
    wr(32'h40, 32'h80000003, "cmd1");            // now N+1
    chk("cmd1_n1_req", {31'b0, gpup_req}, 32'd0);
    tick();                                       // N+2
    chk("cmd1_strobe", {31'b0, gpup_req}, 32'd1);
    chk("cmd1_wdata", gpup_wdata, 32'h80000003);
    chk("cmd1_addr", gpup_addr, 32'h40);
    tick();                                       // N+3
    chk("cmd1_one_shot", {31'b0, gpup_req}, 32'd0);
    chk("cmd1_wdata_off", gpup_wdata, 32'h0);
    ticks(2);                                     // N+5
    gpup_rvalid = 1'b1; gpup_rdata = 32'h00001234;
    tick();
    gpup_rvalid = 1'b0;
    rd(A_STAT, 32'h40000000, "cmd1_status");
    rd(A_RES, 32'h00001234, "cmd1_result");
    rd(A_STAT, 32'h00000000, "cmd1_status_clr");

    // Timeout: err visible the cycle after ISSUE+8
    wr(A_CMD, 32'h11, "to_cmd");
    tick();                                       // I
    chk("to_strobe", {31'b0, gpup_req}, 32'd1);
    ticks(8);                                     // I+8
    rd(A_STAT, 32'h20000000, "to_before");
    rd(A_STAT, 32'h80000000, "to_after");
    wr(A_STAT, 32'h80000000, "to_clr");
    rd(A_STAT, 32'h00000000, "to_cleared");

    // Completion coincident with expiry wins
    wr(A_CMD, 32'h22, "co_cmd");
    tick();                                       // I
    ticks(8);                                     // I+8
    gpup_rvalid = 1'b1; gpup_rdata = 32'h0000CAFE;
    tick();
    gpup_rvalid = 1'b0;
    rd(A_STAT, 32'h40000000, "co_status");
    rd(A_RES, 32'h0000CAFE, "co_result");
    // Stray completion while idle
    gpup_rvalid = 1'b1; gpup_rdata = 32'h0000DEAD;
    tick();
    gpup_rvalid = 1'b0;
    rd(A_STAT, 32'h00000000, "stray_status");
    rd(A_RES, 32'h0000CAFE, "stray_result");

    // Fill, block and drain a silent coprocessor
    strobes.delete();
    for (int i = 0; i < 6; i++) exp_q[i] = 32'hA0 + 32'(i);
    for (int i = 0; i < 5; i++) wr(A_CMD, exp_q[i], "fill");   // now N+5
    rd(A_STAT, 32'h20000004, "fill_full");                     // now N+6
    req = 1'b1; we = 1'b1; addr = A_CMD; wdata = exp_q[5];
    waited = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (gnt) break;
      waited++;
      tick();
    end
    chk("full_wait", 32'(waited), 32'd7);
    tick();                                                    // N+14
    req = 1'b0; we = 1'b0;
    rd(A_STAT, 32'hA0000004, "refill");
    ticks(50);
    rd(A_STAT, 32'h80000000, "drained");
    chk("strobe_cnt", 32'(strobes.size()), 32'd6);
    for (int i = 0; i < 6 && i < strobes.size(); i++)
      chk("strobe_order", strobes[i], exp_q[i]);
    wr(A_STAT, 32'h80000000, "drain_clr");

    // Reset during WAIT with two queued
    wr(A_CMD, 32'h31, "rq1");
    wr(A_CMD, 32'h32, "rq2");
    wr(A_CMD, 32'h33, "rq3");
    tick();                                       // WAIT, count 2
    rst = 1'b1; #1;
    chk("rst_mid_req", {31'b0, gpup_req}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    gpup_rvalid = 1'b1; gpup_rdata = 32'h0000BEEF;
    tick();
    gpup_rvalid = 1'b0;
    rd(A_STAT, 32'h00000000, "rst_mid_status");
    strobes.delete();
    ticks(5);
    chk("rst_no_issue", 32'(strobes.size()), 32'd0);
    rd(A_RES, 32'h00000000, "rst_mid_result");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
